// File: rtl/vxe_fifo_wr_arb.sv
// Round-robin write arbiter: NREQ requesters share one FIFO write port, up to BURST_LEN beats per grant.
// Zero-cycle latency (req_vld -> fifo_wr combinational); fifo_in_rdy=0 stalls the beat but keeps the grant.
module vxe_fifo_wr_arb #(
  parameter int DATA_WIDTH = 32,
  parameter int NREQ       = 4,
  parameter int BURST_LEN  = 4
) (
  input  logic                       clk,
  input  logic                       nrst,
  input  logic [NREQ-1:0]            req_vld,
  input  logic [NREQ*DATA_WIDTH-1:0] req_data,
  output logic [NREQ-1:0]            req_rdy,
  output logic [NREQ-1:0]            grant,
  output logic [DATA_WIDTH-1:0]      fifo_data,
  output logic                       fifo_wr,
  input  logic                       fifo_in_rdy
);

  localparam int PW = (NREQ <= 2) ? 1 : $clog2(NREQ);

  typedef enum logic {IDLE, LOCK} state_t;

  state_t          state, state_nxt;
  logic [PW-1:0]   ptr, ptr_nxt;
  logic [PW-1:0]   owner, owner_nxt;
  logic [7:0]      cnt, cnt_nxt;
  logic [8:0]      cnt_sum;
  logic            win_found;
  logic [PW-1:0]   win_idx;
  logic            gnt_vld;
  logic [PW-1:0]   gnt_idx;

  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] v);
    return (int'(v) == NREQ - 1) ? '0 : v + PW'(1);
  endfunction

  // Scan from the highest offset down so the nearest valid requester after ptr wins last.
  always_comb begin : p_win
    int t;
    logic [PW-1:0] cand;
    t         = 0;
    cand      = '0;
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      t = int'(ptr) + k;
      if (t >= NREQ) t = t - NREQ;
      cand = PW'(t);
      if (req_vld[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  assign cnt_sum = {1'b0, cnt} + 9'd1;

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    owner_nxt = owner;
    cnt_nxt   = cnt;
    gnt_vld   = 1'b0;
    gnt_idx   = '0;
    case (state)
      IDLE: begin
        gnt_vld = win_found;
        gnt_idx = win_idx;
        if (win_found) begin
          if (fifo_in_rdy && BURST_LEN == 1) begin
            ptr_nxt = wrap_inc(win_idx);
          end else begin
            state_nxt = LOCK;
            owner_nxt = win_idx;
            cnt_nxt   = fifo_in_rdy ? 8'd1 : 8'd0;
          end
        end
      end
      LOCK: begin
        gnt_vld = 1'b1;
        gnt_idx = owner;
        if (!req_vld[owner]) begin
          // Owner went away: give up the grant, costing one bubble.
          state_nxt = IDLE;
          ptr_nxt   = wrap_inc(owner);
        end else if (fifo_in_rdy) begin
          cnt_nxt = cnt_sum[7:0];
          if (cnt_sum == 9'(BURST_LEN)) begin
            state_nxt = IDLE;
            ptr_nxt   = wrap_inc(owner);
          end
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state <= IDLE;
      ptr   <= '0;
      owner <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      owner <= owner_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      grant[i] = nrst & gnt_vld & (gnt_idx == PW'(i));
    end
  end

  assign req_rdy   = grant & req_vld & {NREQ{fifo_in_rdy}};
  assign fifo_wr   = |req_rdy;
  assign fifo_data = (nrst && gnt_vld) ? req_data[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH]
                                       : '0;

endmodule

// File: tb/tb_vxe_fifo_wr_arb.sv
// Bench for vxe_fifo_wr_arb (NREQ=4, BURST_LEN=4): per-cycle expected grant tables feed a
// scoreboard queue; req_rdy, fifo_wr and fifo_data expectations derive from the expected grant.
module tb_vxe_fifo_wr_arb;

  localparam int DW = 32;
  localparam int NR = 4;

  logic             clk = 1'b0;
  logic             nrst;
  logic [NR-1:0]    req_vld;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]    req_rdy;
  logic [NR-1:0]    grant;
  logic [DW-1:0]    fifo_data;
  logic             fifo_wr;
  logic             fifo_in_rdy;

  typedef struct packed {
    logic [NR-1:0] g;
    logic          wr;
    logic [NR-1:0] rdy;
    logic [DW-1:0] d;
  } obs_t;

  obs_t sb[$];
  obs_t e, o;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  vxe_fifo_wr_arb #(.DATA_WIDTH(DW), .NREQ(NR), .BURST_LEN(4)) dut (
    .clk(clk), .nrst(nrst), .req_vld(req_vld), .req_data(req_data), .req_rdy(req_rdy),
    .grant(grant), .fifo_data(fifo_data), .fifo_wr(fifo_wr), .fifo_in_rdy(fifo_in_rdy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drive one cycle of stimulus just after the falling edge and push what the outputs must be.
  task automatic drive(input logic n, input logic [NR-1:0] v, input logic f,
                       input logic [NR-1:0] eg);
    obs_t x;
    @(negedge clk);
    cyc++;
    nrst        = n;
    req_vld     = v;
    fifo_in_rdy = f;
    for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = ((i + 1) << 24) | cyc;
    x.g   = eg;
    x.rdy = eg & v & {NR{f}};
    x.wr  = |x.rdy;
    x.d   = '0;
    for (int i = 0; i < NR; i++) if (eg[i]) x.d = ((i + 1) << 24) | cyc;
    sb.push_back(x);
  endtask

  task automatic test_reset_and_rr();
    logic [NR-1:0] eg [19] = '{4'b0000, 4'b0000,
                               4'b0001, 4'b0001, 4'b0001, 4'b0001,
                               4'b0010, 4'b0010, 4'b0010, 4'b0010,
                               4'b0100, 4'b0100, 4'b0100, 4'b0100,
                               4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b0001};
    int writes = 0;
    for (int c = 0; c < 19; c++) begin
      drive(c >= 2, 4'b1111, 1'b1, eg[c]);
      #1;
      o = '{g: grant, wr: fifo_wr, rdy: req_rdy, d: fifo_data};
      e = sb.pop_front();
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL rr_cycle%0d got g=%b wr=%b rdy=%b d=%h exp g=%b wr=%b rdy=%b d=%h",
                 c, o.g, o.wr, o.rdy, o.d, e.g, e.wr, e.rdy, e.d);
      end
      if (c >= 2 && c < 18 && fifo_wr === 1'b1) writes++;
    end
    n_checks++;
    if (writes != 16) begin
      n_fail++;
      $display("FAIL rr_write_count got %0d exp 16", writes);
    end
  endtask

  task automatic test_single_requester();
    logic [NR-1:0] v  [14];
    logic [NR-1:0] eg [14];
    v[0] = 4'b1111; eg[0] = 4'b0000;
    for (int c = 1; c <= 10; c++) begin v[c] = 4'b0100; eg[c] = 4'b0100; end
    v[11] = 4'b0000; eg[11] = 4'b0100;
    v[12] = 4'b0000; eg[12] = 4'b0000;
    v[13] = 4'b1011; eg[13] = 4'b1000;
    for (int c = 0; c < 14; c++) begin
      drive(c != 0, v[c], 1'b1, eg[c]);
      #1;
      o = '{g: grant, wr: fifo_wr, rdy: req_rdy, d: fifo_data};
      e = sb.pop_front();
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL single_cycle%0d got g=%b wr=%b rdy=%b d=%h exp g=%b wr=%b rdy=%b d=%h",
                 c, o.g, o.wr, o.rdy, o.d, e.g, e.wr, e.rdy, e.d);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [NR-1:0] v  [16];
    logic          f  [16];
    logic [NR-1:0] eg [16];
    v[0] = 4'b1111; f[0] = 1'b1; eg[0] = 4'b0000;
    v[1] = 4'b1111; f[1] = 1'b1; eg[1] = 4'b0001;
    v[2] = 4'b1111; f[2] = 1'b1; eg[2] = 4'b0001;
    for (int c = 3; c <= 5; c++) begin v[c] = 4'b1111; f[c] = 1'b0; eg[c] = 4'b0001; end
    v[6] = 4'b1111; f[6] = 1'b1; eg[6] = 4'b0001;
    v[7] = 4'b1111; f[7] = 1'b1; eg[7] = 4'b0001;
    v[8] = 4'b1111; f[8] = 1'b1; eg[8] = 4'b0010;
    // Fresh start: backpressure already present when the grant is first won.
    v[9]  = 4'b0000; f[9]  = 1'b1; eg[9]  = 4'b0000;
    v[10] = 4'b0010; f[10] = 1'b0; eg[10] = 4'b0010;
    for (int c = 11; c <= 14; c++) begin v[c] = 4'b1111; f[c] = 1'b1; eg[c] = 4'b0010; end
    v[15] = 4'b1111; f[15] = 1'b1; eg[15] = 4'b0100;
    for (int c = 0; c < 16; c++) begin
      drive(!(c == 0 || c == 9), v[c], f[c], eg[c]);
      #1;
      o = '{g: grant, wr: fifo_wr, rdy: req_rdy, d: fifo_data};
      e = sb.pop_front();
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL bp_cycle%0d got g=%b wr=%b rdy=%b d=%h exp g=%b wr=%b rdy=%b d=%h",
                 c, o.g, o.wr, o.rdy, o.d, e.g, e.wr, e.rdy, e.d);
      end
    end
  endtask

  task automatic test_owner_drop();
    logic [NR-1:0] v  [6] = '{4'b1111, 4'b0011, 4'b0011, 4'b0010, 4'b0010, 4'b0110};
    logic [NR-1:0] eg [6] = '{4'b0000, 4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0010};
    for (int c = 0; c < 6; c++) begin
      drive(c != 0, v[c], 1'b1, eg[c]);
      #1;
      o = '{g: grant, wr: fifo_wr, rdy: req_rdy, d: fifo_data};
      e = sb.pop_front();
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL drop_cycle%0d got g=%b wr=%b rdy=%b d=%h exp g=%b wr=%b rdy=%b d=%h",
                 c, o.g, o.wr, o.rdy, o.d, e.g, e.wr, e.rdy, e.d);
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    logic          n  [10] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [NR-1:0] v  [10] = '{4'b1111, 4'b0100, 4'b1111, 4'b1111, 4'b1111,
                               4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b1111};
    logic [NR-1:0] eg [10] = '{4'b0000, 4'b0100, 4'b0100, 4'b0000, 4'b0001,
                               4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0010};
    for (int c = 0; c < 10; c++) begin
      drive(n[c], v[c], 1'b1, eg[c]);
      #1;
      o = '{g: grant, wr: fifo_wr, rdy: req_rdy, d: fifo_data};
      e = sb.pop_front();
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL rstmid_cycle%0d got g=%b wr=%b rdy=%b d=%h exp g=%b wr=%b rdy=%b d=%h",
                 c, o.g, o.wr, o.rdy, o.d, e.g, e.wr, e.rdy, e.d);
      end
    end
  endtask

  initial begin
    nrst        = 1'b0;
    req_vld     = '0;
    req_data    = '0;
    fifo_in_rdy = 1'b1;
    test_reset_and_rr();
    test_single_requester();
    test_backpressure();
    test_owner_drop();
    test_reset_mid_burst();
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain got %0d left exp 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vxe_fifo_wr_arb.md
VXE_FIFO_WR_ARB -- requirements
Module: vxe_fifo_wr_arb

Interface
REQ-001 SHALL provide parameter DATA_WIDTH, default 32: width of each requester's data word and of the FIFO write data.
REQ-002 SHALL provide parameter NREQ, default 4, legal range 2..8: number of requesters.
REQ-003 SHALL provide parameter BURST_LEN, default 4, legal range 1..255: maximum consecutive beats per grant.
REQ-004 SHALL have one clock; reset is synchronous and active-low.
REQ-005 clk  input  1  clock; all state updates on the rising edge.
REQ-006 nrst  input  1  synchronous active-low reset.
REQ-007 req_vld  input  NREQ  bit i: requester i presents a word.
REQ-008 req_data  input  NREQ*DATA_WIDTH  requester i word at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-009 req_rdy  output  NREQ  bit i: requester i word accepted this cycle.
REQ-010 grant  output  NREQ  one-hot or zero; the current grant holder.
REQ-011 fifo_data  output  DATA_WIDTH  write data to the downstream FIFO.
REQ-012 fifo_wr  output  1  FIFO write strobe.
REQ-013 fifo_in_rdy  input  1  FIFO not full.

Function
REQ-014 SHALL implement a two-state FSM, IDLE and LOCK, with registers ptr (round-robin priority, 0..NREQ-1), owner (0..NREQ-1) and cnt (8 bits).
REQ-015 In IDLE, winner w SHALL be the first i with req_vld[i]=1, searching ptr, ptr+1, ... modulo NREQ; grant = one-hot(w); grant = 0 if no requester is valid.
REQ-016 In LOCK, grant SHALL be one-hot(owner), regardless of req_vld.
REQ-017 fifo_data SHALL be the req_data slice of the granted index; it SHALL be 0 when grant = 0.
REQ-018 req_rdy[i] SHALL be grant[i] & req_vld[i] & fifo_in_rdy; fifo_wr SHALL be the OR of req_rdy.
REQ-019 Latency SHALL be zero cycles, combinational from req_vld to fifo_wr; there SHALL be no data register in the path.
REQ-020 IDLE, winner exists, fifo_in_rdy=1, BURST_LEN=1: one beat; stay IDLE; ptr <= w+1 mod NREQ.
REQ-021 IDLE, winner exists, fifo_in_rdy=1, BURST_LEN>1: one beat; go to LOCK; owner <= w; cnt <= 1.
REQ-022 IDLE, winner exists, fifo_in_rdy=0: no beat; go to LOCK; owner <= w; cnt <= 0. This holds the grant under backpressure.
REQ-023 IDLE, no valid requester: state, ptr and cnt SHALL be unchanged.
REQ-024 LOCK, req_vld[owner]=1, fifo_in_rdy=1: one beat; cnt <= cnt+1.
  - If cnt+1 = BURST_LEN, go to IDLE and set ptr <= owner+1 mod NREQ.
REQ-025 LOCK, req_vld[owner]=1, fifo_in_rdy=0: hold state, cnt and owner; no beat.
REQ-026 LOCK, req_vld[owner]=0: no beat; go to IDLE; ptr <= owner+1 mod NREQ. This costs exactly one bubble cycle.
REQ-027 Changes to req_vld of non-owners during LOCK SHALL have no effect until the return to IDLE.
REQ-028 ptr and owner SHALL wrap from NREQ-1 to 0.
REQ-029 At most one requester SHALL see req_rdy=1 per cycle.
REQ-030 No beat SHALL be issued when fifo_in_rdy=0.

Reset
REQ-031 On a rising edge with nrst=0: state <= IDLE; ptr <= 0; owner <= 0; cnt <= 0.
REQ-032 While nrst=0, grant, req_rdy and fifo_wr SHALL be forced to 0 and fifo_data to 0.
REQ-033 Reset asserted mid-burst SHALL abandon the burst; no beat is issued in the reset cycle.
  - The first cycle after reset arbitrates from ptr=0.

Verification
REQ-034 Reset with nrst=0 for 2 cycles and req_vld=4'b1111 -> fifo_wr=0 and grant=0 throughout; the first cycle after release gives grant=4'b0001 and fifo_wr=1.
REQ-035 req_vld=4'b1111 held and fifo_in_rdy=1 (NREQ=4, BURST_LEN=4) -> grants 0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3,0...; 16 writes in 16 cycles; data matches the source order.
REQ-036 Only req_vld[2]=1, continuously -> fifo_wr=1 every cycle with no bubble at burst boundaries; grant stays 4'b0100; ptr cycles 3 after each burst.
REQ-037 All valid; fifo_in_rdy=0 for 3 cycles after beat 2 of requester 0 -> grant holds 4'b0001 with fifo_wr=0 and cnt=2 throughout; then beats 3 and 4 complete and grant moves to 4'b0010.
REQ-038 Requester 0 drops req_vld after 2 beats while req_vld[1]=1 -> one cycle with fifo_wr=0 and grant=4'b0001; the next cycle gives grant=4'b0010 with fifo_wr=1.
REQ-039 Reset pulse during beat 3 of requester 2's burst -> no write in the reset cycle; after release the arbiter is in IDLE with ptr=0 and grants requester 0 if valid.
